// File: rtl/mem_stage.sv
// RV32 memory-access stage: issues loads/stores on a req/gnt/rvalid bus,
// aligns and extends load data, flags misalignment and bus timeouts.
`timescale 1ns/1ps
module mem_stage #(
    parameter int unsigned RADDR_WIDTH    = 5,
    parameter int unsigned RDATA_WIDTH    = 32,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   valid_i,
    input  logic [3:0]             mem_op_i,
    input  logic [31:0]            mem_addr_i,
    input  logic [31:0]            mem_wdata_i,
    input  logic [RADDR_WIDTH-1:0] reg_waddr_i,
    input  logic                   reg_we_i,
    input  logic [RDATA_WIDTH-1:0] reg_wdata_i,
    output logic                   stall_o,
    output logic                   data_req_o,
    output logic                   data_we_o,
    output logic [31:0]            data_addr_o,
    output logic [3:0]             data_be_o,
    output logic [31:0]            data_wdata_o,
    input  logic                   data_gnt_i,
    input  logic                   data_rvalid_i,
    input  logic [31:0]            data_rdata_i,
    output logic [RADDR_WIDTH-1:0] reg_waddr_o,
    output logic                   reg_we_o,
    output logic [RDATA_WIDTH-1:0] reg_wdata_o,
    output logic                   exc_misaligned_o,
    output logic                   exc_bus_err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q;
    logic [RDATA_WIDTH-1:0] ld_q;

    logic       is_load, is_store, is_signed, mem_op, misaligned;
    size_t      size;
    logic [3:0] be_d;
    logic [31:0] wdata_d;
    logic [RDATA_WIDTH-1:0] ld_ext;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        start, timeout;

    always_comb begin
        is_load   = 1'b0;
        is_store  = 1'b0;
        is_signed = 1'b0;
        size      = SZ_BYTE;
        case (mem_op_i)
            4'b0001: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_BYTE; end
            4'b0010: begin is_load  = 1'b1; is_signed = 1'b1; size = SZ_HALF; end
            4'b0011: begin is_load  = 1'b1; size = SZ_WORD; end
            4'b0100: begin is_load  = 1'b1; size = SZ_BYTE; end
            4'b0101: begin is_load  = 1'b1; size = SZ_HALF; end
            4'b1001: begin is_store = 1'b1; size = SZ_BYTE; end
            4'b1010: begin is_store = 1'b1; size = SZ_HALF; end
            4'b1011: begin is_store = 1'b1; size = SZ_WORD; end
            default: ;
        endcase
    end

    assign mem_op     = valid_i & (is_load | is_store);
    assign misaligned = ((size == SZ_HALF) && mem_addr_i[0]) ||
                        ((size == SZ_WORD) && (mem_addr_i[1:0] != 2'b00));

    always_comb begin
        be_d    = 4'b1111;
        wdata_d = mem_wdata_i;
        case (size)
            SZ_BYTE: begin
                be_d    = 4'b0001 << mem_addr_i[1:0];
                wdata_d = {4{mem_wdata_i[7:0]}};
            end
            SZ_HALF: begin
                be_d    = mem_addr_i[1] ? 4'b1100 : 4'b0011;
                wdata_d = {2{mem_wdata_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        ld_byte = data_rdata_i[8*mem_addr_i[1:0] +: 8];
        ld_half = mem_addr_i[1] ? data_rdata_i[31:16] : data_rdata_i[15:0];
        ld_ext  = data_rdata_i;
        case (size)
            SZ_BYTE: ld_ext = {{24{is_signed & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_ext = {{16{is_signed & ld_half[15]}}, ld_half};
            default: ;
        endcase
    end

    always_comb begin
        state_d          = state_q;
        start            = 1'b0;
        timeout          = 1'b0;
        stall_o          = 1'b0;
        reg_we_o         = reg_we_i & valid_i;
        reg_waddr_o      = reg_waddr_i;
        reg_wdata_o      = reg_wdata_i;
        exc_misaligned_o = 1'b0;
        exc_bus_err_o    = 1'b0;
        case (state_q)
            IDLE: begin
                if (mem_op) begin
                    reg_we_o = 1'b0;
                    if (misaligned) begin
                        exc_misaligned_o = 1'b1;
                    end else begin
                        stall_o = 1'b1;
                        start   = 1'b1;
                        state_d = REQ;
                    end
                end
            end
            REQ: begin
                stall_o  = 1'b1;
                reg_we_o = 1'b0;
                if (data_gnt_i)             state_d = WAIT;
                else if (cnt_q == CNT_LAST) timeout = 1'b1;
            end
            WAIT: begin
                stall_o  = 1'b1;
                reg_we_o = 1'b0;
                if (data_rvalid_i)          state_d = DONE;
                else if (cnt_q == CNT_LAST) timeout = 1'b1;
            end
            DONE: begin
                state_d = IDLE;
                if (is_load) reg_wdata_o = ld_q;
                else         reg_we_o    = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // A timeout aborts the access and releases the pipeline in the same cycle.
        if (timeout) begin
            stall_o       = 1'b0;
            exc_bus_err_o = 1'b1;
            state_d       = IDLE;
        end
        if (rst_i) begin
            stall_o          = 1'b0;
            reg_we_o         = 1'b0;
            reg_waddr_o      = '0;
            reg_wdata_o      = '0;
            exc_misaligned_o = 1'b0;
            exc_bus_err_o    = 1'b0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q      <= IDLE;
            data_req_o   <= 1'b0;
            data_we_o    <= 1'b0;
            data_addr_o  <= '0;
            data_be_o    <= '0;
            data_wdata_o <= '0;
            cnt_q        <= '0;
            ld_q         <= '0;
        end else begin
            state_q <= state_d;
            if (start) begin
                data_req_o   <= 1'b1;
                data_we_o    <= is_store;
                data_addr_o  <= {mem_addr_i[31:2], 2'b00};
                data_be_o    <= be_d;
                data_wdata_o <= wdata_d;
                cnt_q        <= '0;
            end else begin
                if ((state_q == REQ) || (state_q == WAIT)) cnt_q <= cnt_q + 1'b1;
                if (((state_q == REQ) && data_gnt_i) || timeout) data_req_o <= 1'b0;
            end
            if ((state_q == WAIT) && data_rvalid_i) ld_q <= ld_ext;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Scoreboard bench for mem_stage: expected writebacks queued at issue,
// popped and compared when the instruction leaves the stage.
`timescale 1ns/1ps
module tb_mem_stage;

    logic        clk_i, rst_i, valid_i;
    logic [3:0]  mem_op_i;
    logic [31:0] mem_addr_i, mem_wdata_i;
    logic [4:0]  reg_waddr_i, reg_waddr_o;
    logic        reg_we_i, reg_we_o;
    logic [31:0] reg_wdata_i, reg_wdata_o;
    logic        stall_o, data_req_o, data_we_o;
    logic [31:0] data_addr_o, data_wdata_o, data_rdata_i;
    logic [3:0]  data_be_o;
    logic        data_gnt_i, data_rvalid_i;
    logic        exc_misaligned_o, exc_bus_err_o;

    mem_stage #(
        .RADDR_WIDTH   (5),
        .RDATA_WIDTH   (32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_i           (clk_i),
        .rst_i           (rst_i),
        .valid_i         (valid_i),
        .mem_op_i        (mem_op_i),
        .mem_addr_i      (mem_addr_i),
        .mem_wdata_i     (mem_wdata_i),
        .reg_waddr_i     (reg_waddr_i),
        .reg_we_i        (reg_we_i),
        .reg_wdata_i     (reg_wdata_i),
        .stall_o         (stall_o),
        .data_req_o      (data_req_o),
        .data_we_o       (data_we_o),
        .data_addr_o     (data_addr_o),
        .data_be_o       (data_be_o),
        .data_wdata_o    (data_wdata_o),
        .data_gnt_i      (data_gnt_i),
        .data_rvalid_i   (data_rvalid_i),
        .data_rdata_i    (data_rdata_i),
        .reg_waddr_o     (reg_waddr_o),
        .reg_we_o        (reg_we_o),
        .reg_wdata_o     (reg_wdata_o),
        .exc_misaligned_o(exc_misaligned_o),
        .exc_bus_err_o   (exc_bus_err_o)
    );

    typedef struct {
        logic        valid;
        logic [3:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic [4:0]  waddr;
        logic [31:0] alu;
        int          gnt_delay;
        logic        no_gnt;
    } stim_t;

    typedef struct {
        logic        we;
        logic [4:0]  waddr;
        logic [31:0] wdata;
        logic        chk_wdata;
        logic        mis;
        logic        berr;
        int          stall_n;
        int          req_n;
        logic        bwe;
        logic [31:0] baddr;
        logic [3:0]  be;
        logic [31:0] bwdata;
    } exp_t;

    exp_t exp_q[$];
    int checks = 0;
    int failures = 0;

    // bus responder configuration (written only by the stimulus process)
    int          gnt_delay = 0;
    logic        no_gnt = 1'b0;
    logic [31:0] rdata_val = '0;
    int          late_req = 0;

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Bus slave: grants after gnt_delay request cycles, answers rvalid one cycle later.
    initial begin : responder
        int  wait_cnt;
        bit  pend;
        int  late_seen;
        wait_cnt = 0; pend = 0; late_seen = 0;
        data_gnt_i = 1'b0; data_rvalid_i = 1'b0; data_rdata_i = '0;
        forever begin
            @(posedge clk_i); #1;
            data_gnt_i    = 1'b0;
            data_rvalid_i = 1'b0;
            if (pend) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = rdata_val;
                pend = 0;
            end else if (late_req != late_seen) begin
                data_rvalid_i = 1'b1;
                data_rdata_i  = 32'hFFFF_FFFF;
                late_seen = late_req;
            end else if (data_req_o && !no_gnt) begin
                if (wait_cnt >= gnt_delay) begin
                    data_gnt_i = 1'b1;
                    pend = 1;
                    wait_cnt = 0;
                end else begin
                    wait_cnt++;
                end
            end else if (!data_req_o) begin
                wait_cnt = 0;
            end
        end
    end

    function automatic stim_t st(input logic v, input logic [3:0] op, input logic [31:0] addr,
                                 input logic [31:0] wdata, input logic [31:0] rdata,
                                 input logic [4:0] waddr, input logic [31:0] alu,
                                 input int gd, input logic ng);
        stim_t s;
        s.valid = v; s.op = op; s.addr = addr; s.wdata = wdata; s.rdata = rdata;
        s.waddr = waddr; s.alu = alu; s.gnt_delay = gd; s.no_gnt = ng;
        return s;
    endfunction

    function automatic exp_t ex(input logic we, input logic [4:0] waddr, input logic [31:0] wdata,
                                input logic chk, input logic mis, input logic berr,
                                input int stall_n, input int req_n, input logic bwe,
                                input logic [31:0] baddr, input logic [3:0] be,
                                input logic [31:0] bwdata);
        exp_t e;
        e.we = we; e.waddr = waddr; e.wdata = wdata; e.chk_wdata = chk; e.mis = mis;
        e.berr = berr; e.stall_n = stall_n; e.req_n = req_n; e.bwe = bwe;
        e.baddr = baddr; e.be = be; e.bwdata = bwdata;
        return e;
    endfunction

    // Called just after a rising edge; returns just after the edge that retires the op.
    task automatic run(input string tag, input stim_t s, input exp_t e);
        exp_t got;
        int   stall_n = 0;
        int   req_n = 0;
        bit   retired = 0;
        gnt_delay = s.gnt_delay; no_gnt = s.no_gnt; rdata_val = s.rdata;
        valid_i = s.valid; mem_op_i = s.op; mem_addr_i = s.addr; mem_wdata_i = s.wdata;
        reg_waddr_i = s.waddr; reg_we_i = 1'b1; reg_wdata_i = s.alu;
        exp_q.push_back(e);
        for (int cyc = 0; cyc < 64 && !retired; cyc++) begin
            @(negedge clk_i);
            if (data_req_o) begin
                req_n++;
                check_eq({tag, ".addr"}, data_addr_o, e.baddr);
                check_eq({tag, ".be"}, {28'd0, data_be_o}, {28'd0, e.be});
                check_eq({tag, ".bwe"}, {31'd0, data_we_o}, {31'd0, e.bwe});
                if (e.bwe) check_eq({tag, ".bwdata"}, data_wdata_o, e.bwdata);
            end
            if (stall_o) begin
                stall_n++;
            end else begin
                retired = 1;
                got = exp_q.pop_front();
                check_eq({tag, ".we"}, {31'd0, reg_we_o}, {31'd0, got.we});
                check_eq({tag, ".waddr"}, {27'd0, reg_waddr_o}, {27'd0, got.waddr});
                if (got.chk_wdata) check_eq({tag, ".wdata"}, reg_wdata_o, got.wdata);
                check_eq({tag, ".mis"}, {31'd0, exc_misaligned_o}, {31'd0, got.mis});
                check_eq({tag, ".berr"}, {31'd0, exc_bus_err_o}, {31'd0, got.berr});
                check_eq({tag, ".stall_cycles"}, stall_n, got.stall_n);
                check_eq({tag, ".req_cycles"}, req_n, got.req_n);
            end
            @(posedge clk_i); #1;
        end
        if (!retired) begin
            check_eq({tag, ".retire_timeout"}, 32'd0, 32'd1);
            void'(exp_q.pop_front());
        end
        valid_i = 1'b0; mem_op_i = 4'b0000;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        rst_i = 1'b1; valid_i = 1'b1; mem_op_i = 4'b0000; mem_addr_i = '0; mem_wdata_i = '0;
        reg_waddr_i = 5'd5; reg_we_i = 1'b1; reg_wdata_i = 32'h1234;
        #3;
        check_eq("rst.stall", {31'd0, stall_o}, 32'd0);
        check_eq("rst.we", {31'd0, reg_we_o}, 32'd0);
        check_eq("rst.waddr", {27'd0, reg_waddr_o}, 32'd0);
        check_eq("rst.wdata", reg_wdata_o, 32'd0);
        check_eq("rst.req", {31'd0, data_req_o}, 32'd0);
        check_eq("rst.baddr", data_addr_o, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        run("alu",   st(1, 4'h0, 32'h0,   32'h0,        32'h0,        5'd5, 32'h1234, 0, 0),
                     ex(1, 5'd5, 32'h1234, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("lb",    st(1, 4'h1, 32'h103, 32'h0,        32'h80FF_0000, 5'd9, 32'h5555, 0, 0),
                     ex(1, 5'd9, 32'hFFFF_FF80, 1, 0, 0, 3, 1, 0, 32'h100, 4'b1000, 32'h0));
        run("lbu",   st(1, 4'h4, 32'h103, 32'h0,        32'h80FF_0000, 5'd9, 32'h5555, 0, 0),
                     ex(1, 5'd9, 32'h0000_0080, 1, 0, 0, 3, 1, 0, 32'h100, 4'b1000, 32'h0));
        run("sh",    st(1, 4'hA, 32'h202, 32'hAAAA_BEEF, 32'h0,        5'd9, 32'h5555, 3, 0),
                     ex(0, 5'd9, 32'h0, 0, 0, 0, 6, 4, 1, 32'h200, 4'b1100, 32'hBEEF_BEEF));
        run("lh",    st(1, 4'h2, 32'h102, 32'h0,        32'h8001_1234, 5'd3, 32'h0, 0, 0),
                     ex(1, 5'd3, 32'hFFFF_8001, 1, 0, 0, 3, 1, 0, 32'h100, 4'b1100, 32'h0));
        run("lhu",   st(1, 4'h5, 32'h102, 32'h0,        32'h8001_1234, 5'd3, 32'h0, 0, 0),
                     ex(1, 5'd3, 32'h0000_8001, 1, 0, 0, 3, 1, 0, 32'h100, 4'b1100, 32'h0));
        run("lhlo",  st(1, 4'h2, 32'h100, 32'h0,        32'h8001_1234, 5'd3, 32'h0, 0, 0),
                     ex(1, 5'd3, 32'h0000_1234, 1, 0, 0, 3, 1, 0, 32'h100, 4'b0011, 32'h0));
        run("lw",    st(1, 4'h3, 32'h20,  32'h0,        32'hDEAD_BEEF, 5'd4, 32'h0, 0, 0),
                     ex(1, 5'd4, 32'hDEAD_BEEF, 1, 0, 0, 3, 1, 0, 32'h20, 4'b1111, 32'h0));
        run("sb",    st(1, 4'h9, 32'h11,  32'h0000_00A5, 32'h0,        5'd4, 32'h0, 0, 0),
                     ex(0, 5'd4, 32'h0, 0, 0, 0, 3, 1, 1, 32'h10, 4'b0010, 32'hA5A5_A5A5));
        run("sw",    st(1, 4'hB, 32'h10,  32'h1234_5678, 32'h0,        5'd4, 32'h0, 0, 0),
                     ex(0, 5'd4, 32'h0, 0, 0, 0, 3, 1, 1, 32'h10, 4'b1111, 32'h1234_5678));
        run("lb_odd", st(1, 4'h1, 32'h1,  32'h0,        32'h0000_7F00, 5'd6, 32'h0, 0, 0),
                     ex(1, 5'd6, 32'h0000_007F, 1, 0, 0, 3, 1, 0, 32'h0, 4'b0010, 32'h0));
        run("lw_mis", st(1, 4'h3, 32'h1,  32'h0,        32'h0,        5'd9, 32'h77, 0, 0),
                     ex(0, 5'd9, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("sh_mis", st(1, 4'hA, 32'h203, 32'h0,       32'h0,        5'd9, 32'h77, 0, 0),
                     ex(0, 5'd9, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("lh_mis", st(1, 4'h2, 32'h1,  32'h0,        32'h0,        5'd9, 32'h77, 0, 0),
                     ex(0, 5'd9, 32'h0, 0, 1, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("badop", st(1, 4'h7, 32'h3,   32'h0,        32'h0,        5'd2, 32'h42, 0, 0),
                     ex(1, 5'd2, 32'h42, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("novalid", st(0, 4'h3, 32'h20, 32'h0,       32'h0,        5'd2, 32'h43, 0, 0),
                     ex(0, 5'd2, 32'h43, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("gnt6",  st(1, 4'h3, 32'h30,  32'h0,        32'h1122_3344, 5'd8, 32'h0, 6, 0),
                     ex(1, 5'd8, 32'h1122_3344, 1, 0, 0, 9, 7, 0, 32'h30, 4'b1111, 32'h0));
        run("gnt7",  st(1, 4'h3, 32'h34,  32'h0,        32'h5566_7788, 5'd8, 32'h0, 7, 0),
                     ex(1, 5'd8, 32'h5566_7788, 1, 0, 0, 10, 8, 0, 32'h34, 4'b1111, 32'h0));
        run("tmo",   st(1, 4'h3, 32'h44,  32'h0,        32'h0,        5'd8, 32'h0, 0, 1),
                     ex(0, 5'd8, 32'h0, 0, 0, 1, 8, 8, 0, 32'h44, 4'b1111, 32'h0));

        // stray rvalid after the timeout must not disturb the idle stage
        no_gnt = 1'b0;
        late_req++;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq("late.stall", {31'd0, stall_o}, 32'd0);
            check_eq("late.req", {31'd0, data_req_o}, 32'd0);
            check_eq("late.exc", {30'd0, exc_bus_err_o, exc_misaligned_o}, 32'd0);
        end
        @(posedge clk_i); #1;
        run("alu2",  st(1, 4'h0, 32'h0,   32'h0,        32'h0,        5'd11, 32'hCAFE, 0, 0),
                     ex(1, 5'd11, 32'hCAFE, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));

        // asynchronous reset while the load sits in WAIT
        gnt_delay = 0; rdata_val = 32'h0BAD_0BAD;
        valid_i = 1'b1; mem_op_i = 4'h3; mem_addr_i = 32'h40; mem_wdata_i = 32'hCAFE_F00D;
        reg_waddr_i = 5'd12; reg_we_i = 1'b1; reg_wdata_i = 32'h99;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        check_eq("wait.stall", {31'd0, stall_o}, 32'd1);
        check_eq("wait.baddr", data_addr_o, 32'h40);
        rst_i = 1'b1;
        #1;
        check_eq("arst.stall", {31'd0, stall_o}, 32'd0);
        check_eq("arst.we", {31'd0, reg_we_o}, 32'd0);
        check_eq("arst.wdata", reg_wdata_o, 32'd0);
        check_eq("arst.baddr", data_addr_o, 32'd0);
        check_eq("arst.bwdata", data_wdata_o, 32'd0);
        check_eq("arst.be", {28'd0, data_be_o}, 32'd0);
        @(posedge clk_i); #1;
        rst_i = 1'b0; valid_i = 1'b0;
        @(posedge clk_i); #1;
        run("alu3",  st(1, 4'h0, 32'h0,   32'h0,        32'h0,        5'd13, 32'hBEEF, 0, 0),
                     ex(1, 5'd13, 32'hBEEF, 1, 0, 0, 0, 0, 0, 32'h0, 4'h0, 32'h0));
        run("lw2",   st(1, 4'h3, 32'h48,  32'h0,        32'h0102_0304, 5'd14, 32'h0, 0, 0),
                     ex(1, 5'd14, 32'h0102_0304, 1, 0, 0, 3, 1, 0, 32'h48, 4'b1111, 32'h0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
